record_serializer_tx: RTL and testbench

Transmit-side serializer that accepts one typed record per handshake and emits it as a byte stream: header, payload, then XOR checksum. It is the sending end of the record link and pairs with the existing `record_deserializer_rx`. It sits between record producers (valid/ready) and a byte-wide link or FIFO.

---
 rtl/record_pkg.sv | 35 +++
 rtl/record_tx_out_reg.sv | 59 +++++
 rtl/record_serializer_tx.sv | 170 +++++++++++++++++
 tb/tb_record_serializer_tx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/record_pkg.sv
// Shared record-link definitions for record_serializer_tx and record_deserializer_rx.
// Holds the record payload type, the kind codes, the header layout and the tx state encoding.
package record_pkg;

  localparam int unsigned REC_MAX_BYTES = 8;
  localparam int unsigned HDR_LEN_W     = 6;
  localparam int unsigned IDX_W         = $clog2(REC_MAX_BYTES + 1);
  localparam int unsigned PAY_IDX_W     = $clog2(REC_MAX_BYTES);

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    DATA = 2'd1,
    ADDR = 2'd2,
    CTRL = 2'd3
  } kind_e;

  typedef struct packed {
    kind_e                         kind;
    logic [7:0]                    len;
    logic [REC_MAX_BYTES-1:0][7:0] payload;
  } rec_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_CHK  = 2'd3
  } tx_state_e;

  // Header byte: kind in the top two bits, effective length below.
  function automatic logic [7:0] hdr_byte(kind_e kind, logic [HDR_LEN_W-1:0] len);
    return {kind, len};
  endfunction

endpackage

// File: rtl/record_tx_out_reg.sv
// Single-entry valid/ready holding register for the serialized byte stream.
// A load always wins; otherwise a taken beat empties the slot and clears the markers.
module record_tx_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       sof_i,
  input  logic       eof_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       sof_o,
  output logic       eof_o
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       sof_q, sof_d;
  logic       eof_q, eof_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      sof_d   = sof_i;
      eof_d   = eof_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      data_d  = 8'h00;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sof_o   = sof_q;
  assign eof_o   = eof_q;

endmodule

// File: rtl/record_serializer_tx.sv
// Record serializer: one record per handshake out as header, payload bytes, XOR checksum.
// The output register is loaded on the edge that enters each state, so every beat is registered.
module record_serializer_tx
  import record_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  rec_t       in_rec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       err_len,
  output logic       busy
);

  if (MAX_BYTES < 1 || MAX_BYTES > REC_MAX_BYTES) begin : g_bad_max_bytes
    $fatal(1, "record_serializer_tx: MAX_BYTES out of range 1..REC_MAX_BYTES");
  end

  tx_state_e state_q, state_d;

  logic [REC_MAX_BYTES-1:0][7:0] payload_q, payload_d;
  logic [IDX_W-1:0]              efflen_q, efflen_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [7:0]                    chk_q, chk_d;
  logic                          in_ready_q, in_ready_d;
  logic                          err_len_q, err_len_d;
  logic                          busy_q, busy_d;

  logic                          accept;
  logic                          reject;
  logic                          beat_hs;
  logic [IDX_W-1:0]              in_efflen;
  logic [IDX_W-1:0]              idx_inc;
  logic                          ld;
  logic [7:0]                    ld_data;
  logic                          ld_sof;
  logic                          ld_eof;

  assign accept    = in_valid && in_ready_q;
  assign reject    = (in_rec.kind != NOP) && (in_rec.len > 8'(MAX_BYTES));
  assign beat_hs   = out_valid && out_ready;
  // NOP carries no payload whatever its len field says.
  assign in_efflen = (in_rec.kind == NOP) ? '0 : IDX_W'(in_rec.len);
  assign idx_inc   = idx_q + IDX_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && !reject) state_d = ST_HDR;
      ST_HDR:  if (beat_hs) state_d = (efflen_q != '0) ? ST_PAY : ST_CHK;
      ST_PAY:  if (beat_hs && (idx_inc == efflen_q)) state_d = ST_CHK;
      ST_CHK:  if (beat_hs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output-register load for the byte of the state being entered.
  always_comb begin
    payload_d  = payload_q;
    efflen_d   = efflen_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    err_len_d  = 1'b0;
    ld         = 1'b0;
    ld_data    = 8'h00;
    ld_sof     = 1'b0;
    ld_eof     = 1'b0;
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          payload_d = in_rec.payload;
          efflen_d  = in_efflen;
          idx_d     = '0;
          chk_d     = 8'h00;
          if (reject) begin
            err_len_d = 1'b1;
          end else begin
            ld      = 1'b1;
            ld_data = hdr_byte(in_rec.kind, HDR_LEN_W'(in_efflen));
            ld_sof  = 1'b1;
          end
        end
      end
      ST_HDR: begin
        if (beat_hs) begin
          chk_d = chk_q ^ out_data;
          ld    = 1'b1;
          if (efflen_q != '0) begin
            ld_data = payload_q[0];
          end else begin
            ld_data = chk_d;
            ld_eof  = 1'b1;
          end
        end
      end
      ST_PAY: begin
        if (beat_hs) begin
          chk_d = chk_q ^ out_data;
          idx_d = idx_inc;
          ld    = 1'b1;
          if (idx_inc == efflen_q) begin
            ld_data = chk_d;
            ld_eof  = 1'b1;
          end else begin
            ld_data = payload_q[idx_inc[PAY_IDX_W-1:0]];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload_q  <= '0;
      efflen_q   <= '0;
      idx_q      <= '0;
      chk_q      <= 8'h00;
      in_ready_q <= 1'b0;
      err_len_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      payload_q  <= payload_d;
      efflen_q   <= efflen_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      in_ready_q <= in_ready_d;
      err_len_q  <= err_len_d;
      busy_q     <= busy_d;
    end
  end

  record_tx_out_reg u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ld),
    .data_i  (ld_data),
    .sof_i   (ld_sof),
    .eof_i   (ld_eof),
    .ready_i (out_ready),
    .valid_o (out_valid),
    .data_o  (out_data),
    .sof_o   (out_sof),
    .eof_o   (out_eof)
  );

  assign in_ready = in_ready_q;
  assign err_len  = err_len_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_record_serializer_tx.sv
// Directed bench for record_serializer_tx: expected beats are queued at accept and checked as they leave.
module tb_record_serializer_tx;
  import record_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  rec_t       in_rec = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eof;
  logic       err_len;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [9:0] sbq[$];   // {sof, eof, data}
  int  cyc = 0;
  int  beats = 0;
  int  last_eof_cyc = 0;
  int  last_gap = 0;
  int  rdy_mode = 0;
  int  rdy_cnt = 0;

  record_serializer_tx #(.MAX_BYTES(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rec    (in_rec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .err_len   (err_len),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference framing: header {kind, efflen}, payload bytes, XOR of everything before.
  task automatic push_frame(input rec_t r);
    logic [7:0] eff;
    logic [7:0] hdr;
    logic [7:0] c;
    eff = (r.kind == NOP) ? 8'd0 : r.len;
    hdr = {r.kind, eff[5:0]};
    sbq.push_back({2'b10, hdr});
    c = hdr;
    for (int i = 0; i < int'(eff); i++) begin
      sbq.push_back({2'b00, r.payload[i]});
      c = c ^ r.payload[i];
    end
    sbq.push_back({2'b01, c});
  endtask

  task automatic send(input rec_t r, input bit keep);
    bit got;
    bit rej;
    got = 1'b0;
    rej = (r.kind != NOP) && (r.len > 8'd8);
    @(negedge clk);
    in_rec   = r;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      if (in_ready) begin
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("accept_timeout", 32'(got), 32'd1);
    if (got && !rej) push_frame(r);
    #1;
    if (!keep) in_valid = 1'b0;
    if (rej) begin
      check("rej_err_len", 32'(err_len), 32'd1);
      check("rej_out_valid", 32'(out_valid), 32'd0);
      check("rej_in_ready", 32'(in_ready), 32'd1);
    end else begin
      check("hdr_latency", 32'({out_valid, out_sof}), 32'b11);
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !busy && !out_valid) done = 1'b1;
    end
    check("drain_timeout", 32'(done), 32'd1);
  endtask

  // Output monitor: drive out_ready for the coming edge, then compare the presented beat.
  initial forever begin
    @(negedge clk);
    out_ready = (rdy_mode == 0) ? 1'b1 : ((rdy_cnt % 3) == 0);
    rdy_cnt++;
    if (rst_n && out_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_beat", 32'({out_sof, out_eof, out_data}), 32'h3ff);
      end else begin
        check("beat", 32'({out_sof, out_eof, out_data}), 32'(sbq[0]));
        if (out_ready) begin
          void'(sbq.pop_front());
          beats++;
          if (out_sof) last_gap = cyc - last_eof_cyc;
          if (out_eof) last_eof_cyc = cyc;
        end
      end
    end
  end

  initial begin
    rec_t r;
    rec_t r2;
    int   b0;
    bit   reached;

    // Reset values while held in reset.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bits", 32'({out_data, out_sof, out_eof}), 32'd0);
    check("rst_err_busy", 32'({err_len, busy}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // DATA len 3, continuous ready.
    r = '0;
    r.kind = DATA;
    r.len = 8'd3;
    r.payload[0] = 8'h11;
    r.payload[1] = 8'h22;
    r.payload[2] = 8'h33;
    send(r, 1'b0);
    wait_drain();

    // Same record under 1,0,0 ready pattern.
    rdy_cnt = 0;
    rdy_mode = 1;
    send(r, 1'b0);
    wait_drain();
    rdy_mode = 0;

    // NOP ignores its len field.
    r = '0;
    r.kind = NOP;
    r.len = 8'd5;
    r.payload[0] = 8'hAA;
    send(r, 1'b0);
    wait_drain();

    // Oversized DATA is dropped with a one-cycle err_len.
    r = '0;
    r.kind = DATA;
    r.len = 8'd9;
    send(r, 1'b0);
    @(posedge clk);
    #1;
    check("err_len_pulse_end", 32'(err_len), 32'd0);
    check("rej_no_valid", 32'(out_valid), 32'd0);
    r.len = 8'd0;
    send(r, 1'b0);
    wait_drain();

    // Async reset in the middle of a len 6 frame.
    r = '0;
    r.kind = DATA;
    r.len = 8'd6;
    for (int i = 0; i < 6; i++) r.payload[i] = 8'(8'h50 + i);
    b0 = beats;
    send(r, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 50 && !reached; i++) begin
      @(negedge clk);
      if (beats >= b0 + 3) reached = 1'b1;
    end
    check("midframe_reach", 32'(reached), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bits", 32'({out_data, out_sof, out_eof}), 32'd0);
    check("mid_rst_ctrl", 32'({in_ready, err_len, busy}), 32'd0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_midrst", 32'(in_ready), 32'd1);
    r = '0;
    r.kind = CTRL;
    r.len = 8'd1;
    r.payload[0] = 8'hFF;
    send(r, 1'b0);
    wait_drain();

    // Back-to-back: max-length ADDR then DATA with in_valid held.
    r = '0;
    r.kind = ADDR;
    r.len = 8'd8;
    for (int i = 0; i < 8; i++) r.payload[i] = 8'($urandom_range(0, 255));
    r2 = '0;
    r2.kind = DATA;
    r2.len = 8'd2;
    r2.payload[0] = 8'h5A;
    r2.payload[1] = 8'hC3;
    send(r, 1'b1);
    send(r2, 1'b0);
    wait_drain();
    check("b2b_gap", 32'(last_gap), 32'd2);

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
